// File: rtl/mem_pkg.sv
// Shared encodings for the core-to-memory port arbiter: FSM states, access sizes,
// grant identifiers and the latched request record.
package mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_F_RD = 2'd1;
  localparam logic [1:0] ST_D_RD = 2'd2;
  localparam logic [1:0] ST_D_WR = 2'd3;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        we;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

  // Size code 11 is treated as a full word, so bit 1 alone identifies word accesses.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic mis;
    mis = 1'b0;
    if (is_word(size)) begin
      mis = (lsb != 2'b00);
    end else if (size == SIZE_H) begin
      mis = lsb[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting between the core and a word-write memory: extends sub-word
// loads and merges sub-word store data into the previously read word.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_ext,
  input  logic [31:0] old_word,
  input  logic [31:0] st_data,
  output logic [31:0] st_word
);

  always_comb begin
    ld_ext = ld_word;
    case (size)
      SIZE_B:  ld_ext = {{24{~uns & ld_word[7]}}, ld_word[7:0]};
      SIZE_H:  ld_ext = {{16{~uns & ld_word[15]}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  // The memory always reads from the access address, so the addressed byte sits in lane 0.
  always_comb begin
    st_word = st_data;
    case (size)
      SIZE_B:  st_word = {old_word[31:8], st_data[7:0]};
      SIZE_H:  st_word = {old_word[31:16], st_data[15:0]};
      default: st_word = st_data;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the load/store unit,
// registering read data and performing sub-word stores as atomic read-modify-write.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter logic ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  logic [1:0]  state_q, state_d;
  req_t        req_q, req_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        d_done_q, d_done_d;
  logic        d_err_q, d_err_d;

  logic        idle;
  logic        grant_if;
  logic        grant_d;
  logic        d_mis;
  logic [31:0] ld_ext;
  logic [31:0] st_word;

  assign idle  = (state_q == ST_IDLE);
  assign d_mis = ALIGN_CHECK && is_misaligned(d_size, d_addr[1:0]);

  // On a tie the port not served last wins; a lone request is always served.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (idle) begin
      if (if_req && d_req) begin
        if (last_grant_q == GRANT_IF) begin
          grant_d = 1'b1;
        end else begin
          grant_if = 1'b1;
        end
      end else if (if_req) begin
        grant_if = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  mem_lane_fmt u_lane_fmt (
    .size     (req_q.size),
    .uns      (req_q.uns),
    .ld_word  (mem_rdata),
    .ld_ext   (ld_ext),
    .old_word (buf_q),
    .st_data  (req_q.wdata),
    .st_word  (st_word)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    last_grant_d = last_grant_q;
    buf_d        = buf_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_done_d     = 1'b0;
    d_err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_if) begin
          state_d      = ST_F_RD;
          last_grant_d = GRANT_IF;
          req_d.addr   = if_addr;
          req_d.size   = SIZE_W;
          req_d.we     = 1'b0;
          req_d.uns    = 1'b0;
          req_d.wdata  = '0;
        end else if (grant_d) begin
          last_grant_d = GRANT_D;
          // A misaligned op is dropped without latching, so mem_addr keeps its last value.
          if (d_mis) begin
            d_err_d = 1'b1;
          end else begin
            req_d.addr  = d_addr;
            req_d.size  = d_size;
            req_d.we    = d_we;
            req_d.uns   = d_unsigned;
            req_d.wdata = d_wdata;
            if (d_we && is_word(d_size)) begin
              state_d = ST_D_WR;
            end else begin
              state_d = ST_D_RD;
            end
          end
        end
      end
      ST_F_RD: begin
        if_rdata_d = mem_rdata;
        if_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_D_RD: begin
        // Going straight to D_WR keeps the RMW pair atomic: no grant is possible in between.
        if (req_q.we) begin
          buf_d   = mem_rdata;
          state_d = ST_D_WR;
        end else begin
          d_rdata_d = ld_ext;
          d_done_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_D_WR: begin
        d_done_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      last_grant_q <= GRANT_IF;
      buf_q        <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_done_q     <= 1'b0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      last_grant_q <= last_grant_d;
      buf_q        <= buf_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_done_q     <= d_done_d;
      d_err_q      <= d_err_d;
    end
  end

  assign if_ready  = idle;
  assign d_ready   = idle;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = req_q.addr;
  assign mem_we    = (state_q == ST_D_WR);
  assign mem_wdata = st_word;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers queue expected responses, monitors
// compare them (data and cycle of arrival) against the pulses the arbiter produces.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic        clk;
  logic        reset;
  logic        if_req, if_ready, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_unsigned, d_ready, d_done, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic        if_req_1, if_ready_1, if_valid_1;
  logic [31:0] if_addr_1, if_rdata_1;
  logic        d_req_1, d_we_1, d_unsigned_1, d_ready_1, d_done_1, d_err_1;
  logic [1:0]  d_size_1;
  logic [31:0] d_addr_1, d_wdata_1, d_rdata_1;
  logic [31:0] mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic        mem_we_1;

  logic [7:0]  mem [0:255];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int we_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  typedef struct {
    int          kind;
    logic [31:0] data;
    bit          chk_data;
    int          cyc;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];
  exp_t d1_q[$];

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ALIGN_CHECK(1'b0)) dut_noalign (
    .clk(clk), .reset(reset),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_ready(if_ready_1), .if_valid(if_valid_1), .if_rdata(if_rdata_1),
    .d_req(d_req_1), .d_we(d_we_1), .d_size(d_size_1), .d_unsigned(d_unsigned_1), .d_addr(d_addr_1),
    .d_wdata(d_wdata_1), .d_ready(d_ready_1), .d_done(d_done_1), .d_err(d_err_1), .d_rdata(d_rdata_1),
    .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_we(mem_we_1), .mem_rdata(mem_rdata_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Little-endian memory, combinational read of addr..addr+3, word write at the clock edge.
  always_comb begin
    mem_rdata = {mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
                 mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};
    mem_rdata_1 = {mem[mem_addr_1[7:0] + 8'd3], mem[mem_addr_1[7:0] + 8'd2],
                   mem[mem_addr_1[7:0] + 8'd1], mem[mem_addr_1[7:0]]};
  end

  initial forever begin
    logic [7:0] a;
    @(posedge clk);
    if (mem_we) begin
      a = mem_addr[7:0];
      mem[a]        = mem_wdata[7:0];
      mem[a + 8'd1] = mem_wdata[15:8];
      mem[a + 8'd2] = mem_wdata[23:16];
      mem[a + 8'd3] = mem_wdata[31:24];
    end
  end

  function automatic logic [31:0] rd_word(input logic [31:0] addr);
    logic [7:0] a;
    a = addr[7:0];
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic put_word(input logic [31:0] addr, input logic [31:0] w);
    logic [7:0] a;
    a = addr[7:0];
    mem[a]        = w[7:0];
    mem[a + 8'd1] = w[15:8];
    mem[a + 8'd2] = w[23:16];
    mem[a + 8'd3] = w[31:24];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor for the main instance.
  initial begin : mon
    exp_t e;
    int kind;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (if_valid) begin
          if (if_q.size() == 0) begin
            chk("if_unexpected_pulse", 32'd1, 32'd0);
          end else begin
            e = if_q.pop_front();
            chk("if_rdata", if_rdata, e.data);
            chk("if_latency", 32'(cyc), 32'(e.cyc));
          end
        end
        if (d_done || d_err) begin
          kind = (d_err ? K_ERR : 0) + (d_done ? K_DONE : 0);
          if (d_q.size() == 0) begin
            chk("d_unexpected_pulse", 32'(kind), 32'd0);
          end else begin
            e = d_q.pop_front();
            chk("d_kind", 32'(kind), 32'(e.kind));
            if (e.chk_data) chk("d_rdata", d_rdata, e.data);
            chk("d_latency", 32'(cyc), 32'(e.cyc));
          end
        end
        if (mem_we) begin
          we_cnt++;
          last_waddr = mem_addr;
          last_wdata = mem_wdata;
        end
      end
    end
  end

  // Monitor for the instance built without the alignment check.
  initial begin : mon1
    exp_t e;
    int kind;
    forever begin
      @(negedge clk);
      if (!reset && (d_done_1 || d_err_1)) begin
        kind = (d_err_1 ? K_ERR : 0) + (d_done_1 ? K_DONE : 0);
        if (d1_q.size() == 0) begin
          chk("d1_unexpected_pulse", 32'(kind), 32'd0);
        end else begin
          e = d1_q.pop_front();
          chk("d1_kind", 32'(kind), 32'(e.kind));
          if (e.chk_data) chk("d1_rdata", d_rdata_1, e.data);
          chk("d1_latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!d_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!d_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic d_op(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] wd, input int kind, input logic [31:0] dat, input bit cd,
                      input int lat);
    exp_t e;
    d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
    wait_ready();
    e.kind = kind; e.data = dat; e.chk_data = cd; e.cyc = cyc + lat;
    d_q.push_back(e);
    @(negedge clk);
    d_req = 1'b0;
  endtask

  task automatic if_op(input logic [31:0] a, input logic [31:0] dat);
    exp_t e;
    if_req = 1'b1; if_addr = a;
    wait_ready();
    e.kind = 0; e.data = dat; e.chk_data = 1'b1; e.cyc = cyc + 2;
    if_q.push_back(e);
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((if_q.size() != 0 || d_q.size() != 0 || d1_q.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(if_q.size() + d_q.size() + d1_q.size()), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"},    32'(d_ready),  32'd1);
    chk({tag, "_if_ready"}, 32'(if_ready), 32'd1);
    chk({tag, "_pulses"},   32'({if_valid, d_done, d_err}), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"},  d_rdata,  32'd0);
    chk({tag, "_mem_we"},   32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    exp_t e;
    logic [31:0] exp_a;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put_word(BASE + 32'h00, 32'h0050_0093);
    put_word(BASE + 32'h10, 32'h0000_00F0);
    put_word(BASE + 32'h20, 32'hA5A5_A5A5);
    put_word(BASE + 32'h30, 32'hDEAD_BEEF);
    put_word(BASE + 32'h40, 32'h1122_3344);
    put_word(BASE + 32'h50, 32'h0000_8001);

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = SIZE_W; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
    if_req_1 = 1'b0; if_addr_1 = '0;
    d_req_1 = 1'b0; d_we_1 = 1'b0; d_size_1 = SIZE_W; d_unsigned_1 = 1'b0; d_addr_1 = '0; d_wdata_1 = '0;

    repeat (3) @(negedge clk);
    chk_reset_state("init");
    chk("init_nochk_if_rdata", if_rdata_1, 32'd0);
    chk("init_nochk_mem_we", 32'(mem_we_1), 32'd0);
    chk("init_nochk_mem_wdata", mem_wdata_1, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch only: no write may occur.
    w0 = we_cnt;
    if_op(BASE, 32'h0050_0093);
    drain();
    chk("fetch_no_write", 32'(we_cnt - w0), 32'd0);

    // Sub-word loads, signed and unsigned, back to back.
    d_op(1'b0, SIZE_B, 1'b0, BASE + 32'h10, '0, K_DONE, 32'hFFFF_FFF0, 1'b1, 2);
    d_op(1'b0, SIZE_B, 1'b1, BASE + 32'h10, '0, K_DONE, 32'h0000_00F0, 1'b1, 2);
    d_op(1'b0, SIZE_H, 1'b0, BASE + 32'h50, '0, K_DONE, 32'hFFFF_8001, 1'b1, 2);
    d_op(1'b0, SIZE_H, 1'b1, BASE + 32'h50, '0, K_DONE, 32'h0000_8001, 1'b1, 2);
    drain();

    // SB as RMW, then read back with size code 11 (word).
    w0 = we_cnt;
    d_op(1'b1, SIZE_B, 1'b0, BASE + 32'h40, 32'hFFFF_FFAB, K_DONE, '0, 1'b0, 3);
    d_op(1'b0, 2'b11, 1'b0, BASE + 32'h40, '0, K_DONE, 32'h1122_33AB, 1'b1, 2);
    drain();
    chk("sb_write_count", 32'(we_cnt - w0), 32'd1);
    chk("sb_wdata", last_wdata, 32'h1122_33AB);
    chk("sb_waddr", last_waddr, BASE + 32'h40);

    // Plain SW and LW.
    w0 = we_cnt;
    d_op(1'b1, SIZE_W, 1'b0, BASE + 32'h60, 32'hCAFE_F00D, K_DONE, '0, 1'b0, 2);
    d_op(1'b0, SIZE_W, 1'b0, BASE + 32'h60, '0, K_DONE, 32'hCAFE_F00D, 1'b1, 2);
    drain();
    chk("sw_write_count", 32'(we_cnt - w0), 32'd1);

    // Misaligned accesses are dropped with an error pulse.
    w0 = we_cnt;
    d_op(1'b0, SIZE_H, 1'b0, BASE + 32'h01, '0, K_ERR, '0, 1'b0, 1);
    d_op(1'b1, SIZE_W, 1'b0, BASE + 32'h62, 32'h0000_0000, K_ERR, '0, 1'b0, 1);
    drain();
    chk("mis_no_write", 32'(we_cnt - w0), 32'd0);
    chk("mis_mem_untouched", rd_word(BASE + 32'h60), 32'hCAFE_F00D);

    // Same misaligned LH without the alignment check proceeds normally.
    d_req_1 = 1'b1; d_we_1 = 1'b0; d_size_1 = SIZE_H; d_unsigned_1 = 1'b0; d_addr_1 = BASE + 32'h01;
    chk("noalign_ready", 32'(d_ready_1), 32'd1);
    e.kind = K_DONE; e.data = 32'h0000_5000; e.chk_data = 1'b1; e.cyc = cyc + 2;
    d1_q.push_back(e);
    @(negedge clk);
    d_req_1 = 1'b0;
    drain();

    // Reset asserted in the D_WR cycle of an SW.
    d_req = 1'b1; d_we = 1'b1; d_size = SIZE_W; d_unsigned = 1'b0;
    d_addr = BASE + 32'h30; d_wdata = 32'h0BAD_F00D;
    wait_ready();
    @(negedge clk);
    d_req = 1'b0;
    chk("rst_in_dwr_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_we", 32'(mem_we), 32'd0);
    chk("rst_async_ready", 32'(d_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_word_unchanged", rd_word(BASE + 32'h30), 32'hDEAD_BEEF);
    chk_reset_state("midrst");
    @(negedge clk);

    // Both ports held high: LSU (SH RMW), IF, LSU, IF; fetch never splits the RMW.
    if_req = 1'b1; if_addr = BASE;
    d_req = 1'b1; d_we = 1'b1; d_size = SIZE_H; d_unsigned = 1'b0;
    d_addr = BASE + 32'h20; d_wdata = 32'h0000_1234;
    w0 = cyc;
    e.kind = K_DONE; e.data = '0; e.chk_data = 1'b0; e.cyc = w0 + 3;  d_q.push_back(e);
    e.kind = 0; e.data = 32'h0050_0093; e.chk_data = 1'b1; e.cyc = w0 + 5; if_q.push_back(e);
    e.kind = K_DONE; e.data = '0; e.chk_data = 1'b0; e.cyc = w0 + 8;  d_q.push_back(e);
    e.kind = 0; e.data = 32'h0050_0093; e.chk_data = 1'b1; e.cyc = w0 + 10; if_q.push_back(e);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_a = (k == 4 || k == 5 || k == 9) ? BASE : BASE + 32'h20;
      chk($sformatf("arb_addr_c%0d", k), mem_addr, exp_a);
      chk($sformatf("arb_we_c%0d", k), 32'(mem_we), (k == 2 || k == 7) ? 32'd1 : 32'd0);
    end
    if_req = 1'b0;
    d_req = 1'b0;
    drain();
    chk("sh_result", rd_word(BASE + 32'h20), 32'hA5A5_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
